numbers_const_sequencer: RTL and testbench

Parametrised successor to the fixed constant-output blocks. Holds a DEPTH x WIDTH table of constants, initialised at reset from a base/step formula and rewritable at run time. Streams table entries over a valid/ready interface in one-shot, loop or reverse order. Used as a programmable stimulus/constant source feeding flattened-IO wrappers.

---
 rtl/numbers_pkg.sv | 25 ++
 rtl/numbers_const_table.sv | 33 +++
 rtl/numbers_const_sequencer.sv | 143 ++++++++++++++
 tb/tb_numbers_const_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/numbers_pkg.sv
// Shared types for the constant sequencer: sequence modes, FSM states and the mode decoder.
package numbers_pkg;

    typedef enum logic [1:0] {
        ONESHOT = 2'd0,
        LOOP    = 2'd1,
        REVERSE = 2'd2,
        RSVD    = 2'd3
    } seq_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // The reserved encoding behaves as a one-shot pass.
    function automatic seq_mode_e decode_mode(input logic [1:0] m);
        seq_mode_e d;
        d = seq_mode_e'(m);
        if (d == RSVD) d = ONESHOT;
        return d;
    endfunction

endpackage

// File: rtl/numbers_const_table.sv
// DEPTH x WIDTH constant table: BASE + i*STEP at reset, one write port, one combinational read port.
module numbers_const_table #(
    parameter int          WIDTH = 16,
    parameter int          DEPTH = 8,
    parameter int unsigned BASE  = 32'h00A5,
    parameter int unsigned STEP  = 32'h0011,
    localparam int         AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= WIDTH'(BASE + 32'(i) * STEP);
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A read in the write cycle sees the old contents.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/numbers_const_sequencer.sv
// Streams table constants over valid/ready in one-shot, loop or reverse order.
// Optional out_parity port enabled by defining NUMBERS_SEQ_PARITY_EN.
module numbers_const_sequencer
    import numbers_pkg::*;
#(
    parameter int          WIDTH = 16,
    parameter int          DEPTH = 8,
    parameter int unsigned BASE  = 32'h00A5,
    parameter int unsigned STEP  = 32'h0011,
    localparam int         AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AW:0]      count,
    input  logic             stop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
`ifdef NUMBERS_SEQ_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    // Handshake: a beat transfers on any clock edge where out_valid && out_ready;
    // out_data/out_last are held unchanged while out_valid && !out_ready.

    seq_state_e       state;
    seq_mode_e        mode_q;
    seq_mode_e        mode_dec;
    logic [AW:0]      n_q;
    logic [AW:0]      n_eff;
    logic [AW-1:0]    idx;
    logic [AW-1:0]    start_idx;
    logic [AW-1:0]    next_idx;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             stop_req;
    logic             accept;
    logic             end_seq;
    logic             load;

    numbers_const_table #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .BASE (BASE),
        .STEP (STEP)
    ) u_table (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    function automatic logic is_last(input logic [AW-1:0] i, input seq_mode_e m,
                                     input logic [AW:0] n);
        if (m == REVERSE) return i == '0;
        return i == AW'(n - 1'b1);
    endfunction

    always_comb begin
        mode_dec = decode_mode(mode);
        n_eff    = (count == '0 || count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : count;
        start_idx = (mode_dec == REVERSE) ? AW'(n_eff - 1'b1) : '0;
        if (mode_q == REVERSE)              next_idx = idx - 1'b1;
        else if (idx == AW'(n_q - 1'b1))    next_idx = '0;
        else                                next_idx = idx + 1'b1;
        // The address fetched is always the entry to be presented after the next edge.
        rd_addr  = (state == IDLE) ? start_idx : next_idx;
        accept   = out_valid && out_ready;
        end_seq  = accept && ((mode_q == LOOP) ? (stop || stop_req) : out_last);
        load     = (state == IDLE && start) || (state == RUN && accept && !end_seq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= ONESHOT;
            n_q       <= '0;
            idx       <= '0;
            stop_req  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q    <= mode_dec;
                        n_q       <= n_eff;
                        idx       <= start_idx;
                        out_data  <= rd_data;
                        out_last  <= is_last(start_idx, mode_dec, n_eff);
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (stop && mode_q == LOOP) stop_req <= 1'b1;
                    if (end_seq) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (accept) begin
                        idx      <= next_idx;
                        out_data <= rd_data;
                        out_last <= is_last(next_idx, mode_q, n_q);
                    end
                end
                DONE: begin
                    done     <= 1'b0;
                    stop_req <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NUMBERS_SEQ_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)       out_parity <= 1'b0;
        else if (load) out_parity <= ^rd_data;
    end
`endif

endmodule

// File: tb/tb_numbers_const_sequencer.sv
// Randomized bench for numbers_const_sequencer against an index-list reference model.
// Covers out_parity too when NUMBERS_SEQ_PARITY_EN is defined.
module tb_numbers_const_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic [1:0]  mode;
    logic [3:0]  count;
    logic        stop;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef NUMBERS_SEQ_PARITY_EN
    logic        out_parity;
`endif

    int errors = 0;
    int checks = 0;
    logic [15:0] model_tab [8];

    numbers_const_sequencer dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .mode(mode), .count(count), .stop(stop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
`ifdef NUMBERS_SEQ_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_tab[i] = 16'(16'h00A5 + i * 16'h0011);
    endtask

    // md/cnt: sequence setup; stop_after: beats a LOOP runs before stop;
    // abort_after: beats before a reset (-1 = none); wr_beat: stall that beat and write addr 1.
    task automatic run_seq(input logic [1:0] md, input int cnt, input int stop_after,
                           input int ready_pct, input int abort_after, input int wr_beat,
                           input logic [15:0] wr_val, input bit rnd_wr);
        int n, total, accepted, budget;
        int idx_q[$];
        bit last_q[$];
        logic [15:0] cur_exp;
        bit have, stopped, wrote, rdy;
        n = (cnt == 0 || cnt > 8) ? 8 : cnt;
        total = (md == 2'd1) ? stop_after : n;
        for (int j = 0; j < total; j++) begin
            idx_q.push_back((md == 2'd2) ? n - 1 - j : j % n);
            last_q.push_back((md == 2'd2) ? (j == n - 1) : (j % n == n - 1));
        end
        mode = md; count = 4'(cnt); start = 1'b1;
        step();
        start = 1'b0;
        accepted = 0; budget = 0; have = 0; stopped = 0; wrote = 0;
        while (accepted < total) begin
            if (budget++ > 400) begin
                check("timeout_beats", accepted, total);
                break;
            end
            if (!have) begin
                cur_exp = model_tab[idx_q[0]];
                have = 1;
            end
            check("valid", out_valid, 1);
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            check("data", out_data, cur_exp);
            check("last", out_last, last_q[0]);
`ifdef NUMBERS_SEQ_PARITY_EN
            check("parity", out_parity, ^cur_exp);
`endif
            if (abort_after >= 0 && accepted == abort_after) begin
                out_ready = 1'b0; rst = 1'b1;
                step();
                rst = 1'b0;
                check("abort_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                step();
                check("abort_no_done", done, 0);
                check("abort_idle", out_valid, 0);
                model_reset();
                return;
            end
            rdy = ($urandom_range(0, 99) < ready_pct);
            if (accepted == wr_beat && !wrote) begin
                rdy = 1'b0; wrote = 1;
                wr_en = 1'b1; wr_addr = 3'd1; wr_data = wr_val;
                model_tab[1] = wr_val;
            end else if (!rdy && rnd_wr && $urandom_range(0, 3) == 0) begin
                wr_en = 1'b1; wr_addr = 3'($urandom_range(0, 7)); wr_data = 16'($urandom);
                model_tab[wr_addr] = wr_data;
            end
            if (md == 2'd1) begin
                if (!stopped && accepted == total - 1) begin
                    stop = 1'b1; stopped = 1;
                end
            end else begin
                stop = ($urandom_range(0, 3) == 0);
            end
            start = ($urandom_range(0, 3) == 0);
            if (start) mode = 2'($urandom_range(0, 3));
            out_ready = rdy;
            if (rdy) begin
                void'(idx_q.pop_front());
                void'(last_q.pop_front());
                accepted++;
                have = 0;
            end
            step();
            wr_en = 1'b0; stop = 1'b0; start = 1'b0;
        end
        check("end_valid", out_valid, 0);
        check("end_done", done, 1);
        check("end_busy", busy, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        step();
        check("idle_valid", out_valid, 0);
        check("idle_busy2", busy, 0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        mode = '0; count = '0; stop = 1'b0; out_ready = 1'b0;
        model_reset();
        step();
        step();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        step();

        run_seq(2'd0, 0, 0, 100, -1, -1, 16'h0, 1'b0);
        run_seq(2'd2, 3, 0, 50, -1, -1, 16'h0, 1'b0);
        run_seq(2'd1, 2, 5, 100, -1, -1, 16'h0, 1'b0);
        run_seq(2'd1, 2, 6, 100, -1, 1, 16'hBEEF, 1'b0);
        run_seq(2'd1, 4, 20, 100, 2, -1, 16'h0, 1'b0);
        run_seq(2'd0, 2, 0, 100, -1, -1, 16'h0, 1'b0);
        run_seq(2'd1, 1, 4, 70, -1, -1, 16'h0, 1'b0);
        run_seq(2'd3, 1, 0, 100, -1, -1, 16'h0, 1'b0);

        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                wr_en = 1'b1; wr_addr = 3'($urandom_range(0, 7)); wr_data = 16'($urandom);
                model_tab[wr_addr] = wr_data;
                step();
                wr_en = 1'b0;
            end
            run_seq(2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(1, 12),
                    $urandom_range(30, 100), -1, -1, 16'h0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
